// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared combinational ALU: grant, execute, hold response.
// Build option: define ALU_ARB_FIXED_PRIO_EN to make requester 0 always win ties (no round-robin pointer).
module alu_arbiter #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic             req1_valid,
    input  logic [WIDTH:0]   req0_a,
    input  logic [WIDTH:0]   req0_b,
    input  logic [WIDTH:0]   req1_a,
    input  logic [WIDTH:0]   req1_b,
    input  logic [2:0]       req0_op,
    input  logic [2:0]       req1_op,
    output logic             req0_ready,
    output logic             req1_ready,
    output logic [WIDTH:0]   alu_a,
    output logic [WIDTH:0]   alu_b,
    output logic [2:0]       alu_op,
    output logic             alu_ci,
    input  logic [WIDTH:0]   alu_out,
    input  logic             alu_neg,
    input  logic             alu_zero,
    input  logic             alu_carry,
    input  logic             alu_ovf,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [WIDTH:0]   rsp_out,
    output logic [3:0]       rsp_flags,
    output logic             rsp_err,
    input  logic             rsp_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [2:0] OP_ILLEGAL = 3'b111;

    state_t         state_q, state_d;
    logic [WIDTH:0] opa_q, opa_d;
    logic [WIDTH:0] opb_q, opb_d;
    logic [2:0]     opc_q, opc_d;
    logic           id_q, id_d;
    logic [WIDTH:0] out_q, out_d;
    logic [3:0]     flags_q, flags_d;
    logic           err_q, err_d;
    logic           grant_any;
    logic           grant_id;

`ifndef ALU_ARB_FIXED_PRIO_EN
    // Holds the id granted most recently; a tie goes to the other requester.
    logic           last_q, last_d;
`endif

    always_comb begin
        grant_any = 1'b0;
        grant_id  = 1'b0;
        if (state_q == IDLE && !rst) begin
            if (req0_valid && req1_valid) begin
                grant_any = 1'b1;
`ifdef ALU_ARB_FIXED_PRIO_EN
                grant_id  = 1'b0;
`else
                grant_id  = ~last_q;
`endif
            end else if (req0_valid) begin
                grant_any = 1'b1;
                grant_id  = 1'b0;
            end else if (req1_valid) begin
                grant_any = 1'b1;
                grant_id  = 1'b1;
            end
        end
    end

    assign req0_ready = grant_any && !grant_id;
    assign req1_ready = grant_any && grant_id;

    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        opc_d   = opc_q;
        id_d    = id_q;
        out_d   = out_q;
        flags_d = flags_q;
        err_d   = err_q;
`ifndef ALU_ARB_FIXED_PRIO_EN
        last_d  = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (grant_any) begin
                    state_d = EXEC;
                    id_d    = grant_id;
                    opa_d   = grant_id ? req1_a  : req0_a;
                    opb_d   = grant_id ? req1_b  : req0_b;
                    opc_d   = grant_id ? req1_op : req0_op;
`ifndef ALU_ARB_FIXED_PRIO_EN
                    last_d  = grant_id;
`endif
                end
            end
            EXEC: begin
                // Illegal opcode: whatever the ALU produces is discarded.
                if (opc_q == OP_ILLEGAL) begin
                    out_d   = '0;
                    flags_d = 4'b0000;
                    err_d   = 1'b1;
                end else begin
                    out_d   = alu_out;
                    flags_d = {alu_neg, alu_zero, alu_carry, alu_ovf};
                    err_d   = 1'b0;
                end
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            opc_q   <= 3'b000;
            id_q    <= 1'b0;
            out_q   <= '0;
            flags_q <= 4'b0000;
            err_q   <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            opc_q   <= opc_d;
            id_q    <= id_d;
            out_q   <= out_d;
            flags_q <= flags_d;
            err_q   <= err_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_q  <= last_d;
`endif
        end
    end

    assign alu_a     = opa_q;
    assign alu_b     = opb_q;
    assign alu_op    = opc_q;
    assign alu_ci    = 1'b0;
    assign rsp_valid = (state_q == RESP);
    assign rsp_id    = id_q;
    assign rsp_out   = out_q;
    assign rsp_flags = flags_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: transaction-level reference model, directed scenarios, then random traffic.
module tb_alu_arbiter;

`ifdef ALU_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req1_valid;
    logic [3:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0] req0_op, req1_op;
    logic       req0_ready, req1_ready;
    logic [3:0] alu_a, alu_b;
    logic [2:0] alu_op;
    logic       alu_ci;
    logic [3:0] alu_out;
    logic       alu_neg, alu_zero, alu_carry, alu_ovf;
    logic       rsp_valid, rsp_id;
    logic [3:0] rsp_out;
    logic [3:0] rsp_flags;
    logic       rsp_err;
    logic       rsp_ready;

    int total = 0;
    int bad   = 0;
    bit started = 1'b0;

    alu_arbiter #(.WIDTH(3)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .req0_op(req0_op), .req1_op(req1_op),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_ci(alu_ci),
        .alu_out(alu_out), .alu_neg(alu_neg), .alu_zero(alu_zero),
        .alu_carry(alu_carry), .alu_ovf(alu_ovf),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_out(rsp_out),
        .rsp_flags(rsp_flags), .rsp_err(rsp_err), .rsp_ready(rsp_ready)
    );

    always #5 clk = ~clk;

    // Shared ALU as seen by the arbiter: returns {out, N, Z, C, V}.
    // Opcode 111 deliberately yields non-zero garbage so masking is observable.
    function automatic logic [7:0] alu_fn(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        logic [4:0] s;
        logic [3:0] o;
        logic       c, v;
        s = 5'd0; o = 4'd0; c = 1'b0; v = 1'b0;
        case (op)
            3'b000: o = a & b;
            3'b001: begin s = {1'b0, a} + {1'b0, b}; o = s[3:0]; c = s[4];
                          v = (a[3] == b[3]) && (o[3] != a[3]); end
            3'b010: begin s = {1'b0, a} + {1'b0, ~b} + 5'd1; o = s[3:0]; c = s[4];
                          v = (a[3] != b[3]) && (o[3] != a[3]); end
            3'b011: o = a | b;
            3'b100: o = a ^ b;
            3'b101: begin o = {a[2:0], 1'b0}; c = a[3]; end
            3'b110: begin o = {1'b0, a[3:1]}; c = a[0]; end
            default: begin o = a; c = 1'b1; v = 1'b1; end
        endcase
        return {o, o[3], (o == 4'd0), c, v};
    endfunction

    logic [7:0] alu_res;
    always_comb alu_res = alu_fn(alu_a, alu_b, alu_op);
    assign alu_out   = alu_res[7:4];
    assign alu_neg   = alu_res[3];
    assign alu_zero  = alu_res[2];
    assign alu_carry = alu_res[1];
    assign alu_ovf   = alu_res[0];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding transaction, tracked by its age since acceptance.
    bit         m_busy = 1'b0;
    int         m_age  = 0;
    bit         m_last = 1'b1;
    logic [3:0] m_a = 4'd0, m_b = 4'd0;
    logic [2:0] m_op = 3'd0;
    bit         m_id = 1'b0;
    logic [3:0] m_out = 4'd0, m_flags = 4'd0;
    bit         m_err = 1'b0;

    always @(negedge clk) begin
        bit         eg_any, eg_id, eresp;
        logic [7:0] r;
        if (started) begin
            eg_any = 1'b0;
            eg_id  = 1'b0;
            if (!rst && !m_busy) begin
                if (req0_valid && req1_valid) begin
                    eg_any = 1'b1;
                    eg_id  = FIXED ? 1'b0 : ~m_last;
                end else if (req0_valid || req1_valid) begin
                    eg_any = 1'b1;
                    eg_id  = req1_valid;
                end
            end
            eresp = m_busy && (m_age >= 2);
            chk("req0_ready", 32'(req0_ready), 32'(eg_any && !eg_id));
            chk("req1_ready", 32'(req1_ready), 32'(eg_any && eg_id));
            chk("rsp_valid", 32'(rsp_valid), 32'(eresp));
            chk("alu_a", 32'(alu_a), 32'(m_a));
            chk("alu_b", 32'(alu_b), 32'(m_b));
            chk("alu_op", 32'(alu_op), 32'(m_op));
            chk("alu_ci", 32'(alu_ci), 32'd0);
            if (eresp) begin
                chk("rsp_id", 32'(rsp_id), 32'(m_id));
                chk("rsp_out", 32'(rsp_out), 32'(m_out));
                chk("rsp_flags", 32'(rsp_flags), 32'(m_flags));
                chk("rsp_err", 32'(rsp_err), 32'(m_err));
            end
            if (rst) begin
                m_busy = 1'b0; m_last = 1'b1;
                m_a = 4'd0; m_b = 4'd0; m_op = 3'd0;
            end else if (eg_any) begin
                m_busy = 1'b1; m_age = 1; m_last = eg_id; m_id = eg_id;
                m_a  = eg_id ? req1_a  : req0_a;
                m_b  = eg_id ? req1_b  : req0_b;
                m_op = eg_id ? req1_op : req0_op;
                r = alu_fn(m_a, m_b, m_op);
                m_err   = (m_op == 3'b111);
                m_out   = m_err ? 4'd0 : r[7:4];
                m_flags = m_err ? 4'd0 : r[3:0];
            end else if (m_busy) begin
                if (m_age >= 2) begin
                    if (rsp_ready) m_busy = 1'b0;
                end else begin
                    m_age++;
                end
            end
        end
    end

    task automatic drive(input int id, input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        if (id == 0) begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op; end
        else         begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op; end
    endtask

    // Issue one op with rsp_ready=1 and check the response against literal values.
    task automatic run_one(input string nm, input int id, input logic [3:0] a, input logic [3:0] b,
                           input logic [2:0] op, input logic [3:0] eout, input logic eerr);
        bit got;
        got = 1'b0;
        rsp_ready = 1'b1;
        drive(id, a, b, op);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((id == 0) ? req0_ready : req1_ready) begin got = 1'b1; break; end
        end
        chk({nm, "_grant"}, 32'(got), 32'd1);
        @(posedge clk); #1;
        if (id == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
        @(negedge clk);
        chk({nm, "_n1_valid"}, 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk({nm, "_n2_valid"}, 32'(rsp_valid), 32'd1);
        chk({nm, "_id"}, 32'(rsp_id), 32'(id));
        chk({nm, "_out"}, 32'(rsp_out), 32'(eout));
        chk({nm, "_err"}, 32'(rsp_err), 32'(eerr));
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int         order[8];
        int         exp_order[8];
        int         k, cnt0, cnt1;
        bit         g0, g1, a0, a1;
        logic [3:0] snap_out, snap_flags;

        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = 4'd0; req0_b = 4'd0; req0_op = 3'd0;
        req1_a = 4'd0; req1_b = 4'd0; req1_op = 3'd0;
        rsp_ready = 1'b1;
        @(posedge clk);
        started = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;

        @(negedge clk);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_out", 32'(rsp_out), 32'd0);
        chk("rst_rsp_flags", 32'(rsp_flags), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'd0);
        @(posedge clk); #1;

        run_one("add", 0, 4'b0111, 4'b0010, 3'b001, 4'b1001, 1'b0);
        run_one("sub_zero", 1, 4'b0101, 4'b0101, 3'b010, 4'b0000, 1'b0);
        @(negedge clk);
        chk("sub_zero_zflag", 32'(rsp_flags[2]), 32'd1);
        @(posedge clk); #1;
        run_one("illegal", 0, 4'b1101, 4'b0011, 3'b111, 4'b0000, 1'b1);
        @(negedge clk);
        chk("illegal_flags", 32'(rsp_flags), 32'd0);
        @(posedge clk); #1;

        // Tie: both requesters keep a request up until each has had four grants.
        do_reset();
        for (int i = 0; i < 8; i++)
            exp_order[i] = FIXED ? ((i < 4) ? 0 : 1) : (i % 2);
        k = 0; cnt0 = 0; cnt1 = 0;
        rsp_ready = 1'b1;
        drive(0, 4'($urandom), 4'($urandom), 3'($urandom));
        drive(1, 4'($urandom), 4'($urandom), 3'($urandom));
        for (int c = 0; c < 200 && (cnt0 < 4 || cnt1 < 4); c++) begin
            @(negedge clk);
            g0 = req0_valid && req0_ready;
            g1 = req1_valid && req1_ready;
            if (g0 && k < 8) begin order[k] = 0; k++; end
            if (g1 && k < 8) begin order[k] = 1; k++; end
            @(posedge clk); #1;
            if (g0) begin
                cnt0++;
                if (cnt0 == 4) req0_valid = 1'b0;
                else drive(0, 4'($urandom), 4'($urandom), 3'($urandom));
            end
            if (g1) begin
                cnt1++;
                if (cnt1 == 4) req1_valid = 1'b0;
                else drive(1, 4'($urandom), 4'($urandom), 3'($urandom));
            end
        end
        chk("tie_count", 32'(k), 32'd8);
        for (int i = 0; i < 8; i++)
            chk($sformatf("tie_order%0d", i), 32'(order[i]), 32'(exp_order[i]));
        repeat (3) @(posedge clk);
        #1;

        // Backpressure with requester 1 waiting behind an OR from requester 0.
        rsp_ready = 1'b0;
        drive(0, 4'b0011, 4'b0100, 3'b011);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req0_ready) break;
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        drive(1, 4'b1000, 4'b0001, 3'b100);
        @(negedge clk);
        @(negedge clk);
        snap_out = rsp_out;
        snap_flags = rsp_flags;
        chk("bp_out_lit", 32'(snap_out), 32'b0111);
        chk("bp_valid", 32'(rsp_valid), 32'd1);
        repeat (5) begin
            @(negedge clk);
            chk("bp_stable_out", 32'(rsp_out), 32'(snap_out));
            chk("bp_stable_flags", 32'(rsp_flags), 32'(snap_flags));
            chk("bp_req1_wait", 32'(req1_ready), 32'd0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_same", 32'(req1_ready), 32'd0);
        @(negedge clk);
        chk("bp_release_next", 32'(req1_ready), 32'd1);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // Reset while a response is being held; requester 1 waits across the reset.
        rsp_ready = 1'b0;
        drive(0, 4'b0001, 4'b0001, 3'b001);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req0_ready) break;
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rr_held", 32'(rsp_valid), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        drive(1, 4'b0110, 4'b0011, 3'b000);
        @(negedge clk);
        chk("rr_ready_in_rst", 32'(req1_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("rr_dropped", 32'(rsp_valid), 32'd0);
        chk("rr_idle_grant", 32'(req1_ready), 32'd1);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // Random traffic, random backpressure, occasional reset.
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            a0 = req0_valid && req0_ready;
            a1 = req1_valid && req1_ready;
            @(posedge clk); #1;
            if (a0) req0_valid = 1'b0;
            if (a1) req1_valid = 1'b0;
            if (!req0_valid && $urandom_range(0, 9) < 4)
                drive(0, 4'($urandom), 4'($urandom), 3'($urandom));
            if (!req1_valid && $urandom_range(0, 9) < 4)
                drive(1, 4'($urandom), 4'($urandom), 3'($urandom));
            rsp_ready = ($urandom_range(0, 9) < 7);
            rst = ($urandom_range(0, 99) == 0);
        end
        rst = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
